// File: rtl/phoenix_switch_control.sv
// Phoenix router switch control: round-robin header arbitration, XY routing,
// and the crossbar connection table, held until the granted buffer stops sending.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module phoenix_switch_control #(
  parameter logic [7:0] ADDR     = 8'h00,
  parameter int         NPORT    = 5,
  parameter int         TAM_FLIT = `TAM_FLIT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NPORT-1:0]          i_h,
  input  logic [NPORT*TAM_FLIT-1:0] i_data,
  input  logic [NPORT-1:0]          i_sender,
  output logic [NPORT-1:0]          o_ack_h,
  output logic [NPORT-1:0]          o_free,
  output logic [NPORT*3-1:0]        o_mux_in,
  output logic [NPORT*3-1:0]        o_mux_out
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

  state_t             state, state_n;
  logic [2:0]         last, sel, dest_q, dest, pick, idx, src;
  logic               found;
  logic [7:0]         hdr;
  logic [NPORT-1:0]   sender_q, free_q, rel, ack;
  logic [NPORT*3-1:0] mux_in_q, mux_out_q;
  logic [3:0]         tx, ty;

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= int'(NPORT); k++) begin
      idx = 3'((int'(last) + k) % int'(NPORT));
      if (!found && i_h[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign tx = hdr[7:4];
  assign ty = hdr[3:0];

  always_comb begin
    if (tx > ADDR[7:4])      dest = 3'd0;
    else if (tx < ADDR[7:4]) dest = 3'd1;
    else if (ty > ADDR[3:0]) dest = 3'd2;
    else if (ty < ADDR[3:0]) dest = 3'd3;
    else                     dest = 3'd4;
  end

  // Busy output p frees when its connected input's sender just fell.
  always_comb begin
    rel = '0;
    src = '0;
    for (int unsigned p = 0; p < int'(NPORT); p++) begin
      src = mux_in_q[p*3 +: 3];
      if (!free_q[3'(p)] && sender_q[src] && !i_sender[src])
        rel[3'(p)] = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    ack     = '0;
    case (state)
      S_IDLE:  if (|i_h) state_n = S_ARB;
      S_ARB:   state_n = found ? S_ROUTE : S_IDLE;
      S_ROUTE: state_n = free_q[dest] ? S_GRANT : S_IDLE;
      S_GRANT: begin
        ack[sel] = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= S_IDLE;
      last      <= 3'(NPORT - 1);
      sel       <= '0;
      hdr       <= '0;
      dest_q    <= '0;
      sender_q  <= '0;
      free_q    <= '1;
      mux_in_q  <= '0;
      mux_out_q <= '0;
    end else begin
      state    <= state_n;
      sender_q <= i_sender;
      if (state == S_ARB && found) begin
        sel  <= pick;
        last <= pick;
        hdr  <= i_data[int'(pick)*TAM_FLIT +: 8];
      end
      if (state == S_ROUTE) dest_q <= dest;
      // Grant only hits a free port and release only a busy one, so the later write never collides.
      free_q <= free_q | rel;
      if (state == S_GRANT) begin
        free_q[dest_q]                  <= 1'b0;
        mux_in_q[int'(dest_q)*3 +: 3]   <= sel;
        mux_out_q[int'(sel)*3 +: 3]     <= dest_q;
      end
    end
  end

  assign o_ack_h   = ack;
  assign o_free    = free_q;
  assign o_mux_in  = mux_in_q;
  assign o_mux_out = mux_out_q;

endmodule

// File: tb/tb_phoenix_switch_control.sv
// Directed bench for phoenix_switch_control at router address 8'h11.
module tb_phoenix_switch_control;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [4:0]  i_h = '0, i_sender = '0;
  logic [79:0] i_data = '0;
  logic [4:0]  o_ack_h, o_free;
  logic [14:0] o_mux_in, o_mux_out;

  int n_tests = 0;
  int n_fail  = 0;
  int found;

  phoenix_switch_control #(.ADDR(8'h11), .NPORT(5), .TAM_FLIT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_h(i_h), .i_data(i_data), .i_sender(i_sender),
    .o_ack_h(o_ack_h), .o_free(o_free), .o_mux_in(o_mux_in), .o_mux_out(o_mux_out)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_hdr(input int port, input logic [7:0] h);
    i_data[port*16 +: 16] = {8'hA5, h};
  endtask

  // Call with the FSM in IDLE; returns in the cycle after the grant with i_h cleared.
  task automatic route_one(input string tag, input int port, input logic [7:0] h, input int dest);
    logic [4:0] one;
    one = 5'b00001 << port;
    set_hdr(port, h);
    i_h = one;
    chk({tag, "_c0"}, 32'(o_ack_h), 32'h0);
    tick(); chk({tag, "_c1"}, 32'(o_ack_h), 32'h0);
    tick(); chk({tag, "_c2"}, 32'(o_ack_h), 32'h0);
    tick(); chk({tag, "_ack"}, 32'(o_ack_h), 32'(one));
    tick(); chk({tag, "_c4"}, 32'(o_ack_h), 32'h0);
    chk({tag, "_busy"}, 32'(o_free[dest]), 32'h0);
    chk({tag, "_muxin"}, 32'(o_mux_in[dest*3 +: 3]), 32'(port));
    chk({tag, "_muxout"}, 32'(o_mux_out[port*3 +: 3]), 32'(dest));
    i_h = '0;
  endtask

  initial begin
    // Reset with random inputs
    i_rst = 1'b0;
    i_h = 5'($urandom); i_sender = 5'($urandom);
    i_data = {16'($urandom), 32'($urandom), 32'($urandom)};
    tick();
    i_h = 5'($urandom); i_sender = 5'($urandom);
    i_data = {16'($urandom), 32'($urandom), 32'($urandom)};
    tick();
    chk("rst_ack", 32'(o_ack_h), 32'h0);
    chk("rst_free", 32'(o_free), 32'h1f);
    chk("rst_muxin", 32'(o_mux_in), 32'h0);
    chk("rst_muxout", 32'(o_mux_out), 32'h0);
    i_h = '0; i_sender = '0; i_data = '0;
    i_rst = 1'b1;

    // Single routes from WEST input to every output
    route_one("east",  1, 8'h21, 0);
    route_one("local", 1, 8'h11, 4);
    route_one("south", 1, 8'h10, 3);
    route_one("west",  1, 8'h01, 1);
    route_one("north", 1, 8'h12, 2);

    // Release: all five outputs are held by input 1 and free together
    i_sender[1] = 1'b1;
    repeat (6) tick();
    i_sender[1] = 1'b0;
    chk("rel_before", 32'(o_free), 32'h00);
    tick();
    chk("rel_after", 32'(o_free), 32'h1f);
    chk("rel_muxin0", 32'(o_mux_in[2:0]), 32'h1);
    chk("rel_muxin4", 32'(o_mux_in[14:12]), 32'h1);

    // Round robin
    i_rst = 1'b0; tick(); i_rst = 1'b1;
    set_hdr(0, 8'h21); set_hdr(2, 8'h12); set_hdr(4, 8'h11);
    i_h = 5'b10101;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      if (cyc == 4) set_hdr(0, 8'h10);
      case (cyc)
        3:       chk("rr_ack", 32'(o_ack_h), 32'h01);
        7:       chk("rr_ack", 32'(o_ack_h), 32'h04);
        11:      chk("rr_ack", 32'(o_ack_h), 32'h10);
        15:      chk("rr_ack", 32'(o_ack_h), 32'h01);
        default: chk("rr_idle", 32'(o_ack_h), 32'h0);
      endcase
    end
    chk("rr_muxout0", 32'(o_mux_out[2:0]), 32'h3);
    chk("rr_muxin3", 32'(o_mux_in[11:9]), 32'h0);
    chk("rr_free", 32'(o_free), 32'h02);
    i_h = '0;

    // Blocked output
    i_rst = 1'b0; tick(); i_rst = 1'b1;
    route_one("blk_w", 1, 8'h21, 0);
    i_sender = 5'b00010;
    set_hdr(4, 8'h21);
    i_h = 5'b10000;
    repeat (12) begin
      tick();
      chk("blk_noack", 32'(o_ack_h), 32'h0);
    end
    chk("blk_busy", 32'(o_free[0]), 32'h0);
    i_sender = '0;
    found = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (found == 0 && o_ack_h != 5'b0) begin
        found = 1;
        chk("blk_ack", 32'(o_ack_h), 32'h10);
      end
    end
    chk("blk_ack_seen", 32'(found), 32'h1);
    i_h = '0;
    tick();
    chk("blk_muxin0", 32'(o_mux_in[2:0]), 32'h4);
    chk("blk_muxout4", 32'(o_mux_out[14:12]), 32'h0);
    chk("blk_busy2", 32'(o_free[0]), 32'h0);
    repeat (3) tick();

    // Reset mid-connection
    route_one("mid", 2, 8'h01, 1);
    i_sender = 5'b10100;
    tick();
    chk("mid_open", 32'(o_free), 32'h1c);
    i_rst = 1'b0;
    tick();
    i_rst = 1'b1;
    chk("mid_free", 32'(o_free), 32'h1f);
    chk("mid_ack", 32'(o_ack_h), 32'h0);
    chk("mid_muxin", 32'(o_mux_in), 32'h0);
    repeat (3) begin
      tick();
      chk("mid_quiet", 32'(o_ack_h | {~o_free}), 32'h0);
    end
    route_one("post", 3, 8'h10, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
